// File: rtl/midi_note_decoder_pkg.sv
// Shared MIDI constants and FSM state encodings for the note decoder slice.
package midi_note_decoder_pkg;

  // Channel message status nibbles (upper nibble of a status byte)
  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHPRESS  = 4'hD;

  // Controller numbers that silence everything
  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  // Decoder FSM states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_D1 = 2'd1;
  localparam logic [1:0] S_WAIT_D2 = 2'd2;
  localparam logic [1:0] S_SKIP    = 2'd3;

  // Message types this decoder acts on; everything else is skipped
  function automatic logic is_supported(input logic [3:0] typ);
    return (typ == ST_NOTE_OFF) || (typ == ST_NOTE_ON) || (typ == ST_CC);
  endfunction

endpackage

// File: rtl/midi_note_decoder_byte_class.sv
// Combinational classifier: splits a received MIDI byte into its class flags,
// the message type / channel nibbles and the data length of the message.
module midi_note_decoder_byte_class
  import midi_note_decoder_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_rt,
  output logic       o_is_sys,
  output logic       o_is_status,
  output logic       o_is_data,
  output logic [3:0] o_type,
  output logic [3:0] o_chan,
  output logic [1:0] o_skip_len
);

  // 0xF8-0xFF realtime, 0xF0-0xF7 system common / sysex
  assign o_is_rt     = (i_byte[7:3] == 5'b11111);
  assign o_is_sys    = (i_byte[7:3] == 5'b11110);
  assign o_is_status = i_byte[7] && (i_byte[7:4] != 4'hF);
  assign o_is_data   = ~i_byte[7];
  assign o_type      = i_byte[7:4];
  assign o_chan      = i_byte[3:0];

  // Program change and channel pressure carry one data byte, the rest two
  assign o_skip_len  = ((i_byte[7:4] == ST_PROG) || (i_byte[7:4] == ST_CHPRESS)) ? 2'd1 : 2'd2;

endmodule

// File: rtl/midi_note_decoder.sv
// MIDI byte-stream note decoder: running status, channel filter, realtime
// pass-over and all-notes-off detection. All outputs are registered.
//
// Handshake: i_byte_valid is a one-cycle strobe with no back-pressure; one byte
// may be presented every cycle and is consumed in the cycle it is strobed.
// Pulse outputs rise exactly one cycle after the strobe of the completing data byte.
module midi_note_decoder
  import midi_note_decoder_pkg::*;
#(
  parameter int OMNI = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte_in,
  input  logic [3:0] i_channel,
  output logic       o_note_on,
  output logic       o_note_off,
  output logic [6:0] o_note,
  output logic [6:0] o_velocity,
  output logic       o_all_off,
  output logic [1:0] o_state
);

  logic       w_is_rt;
  logic       w_is_sys;
  logic       w_is_status;
  logic       w_is_data;
  logic [3:0] w_type;
  logic [3:0] w_chan;
  logic [1:0] w_skip_len;
  logic       w_match;
  logic [6:0] w_data;

  logic [1:0] r_state;
  logic [3:0] r_type;
  logic [6:0] r_d1;
  logic [1:0] r_skip_len;
  logic [1:0] r_skip_cnt;
  logic       r_note_on;
  logic       r_note_off;
  logic       r_all_off;
  logic [6:0] r_note;
  logic [6:0] r_velocity;

  midi_note_decoder_byte_class u_byte_class (
    .i_byte      (i_byte_in),
    .o_is_rt     (w_is_rt),
    .o_is_sys    (w_is_sys),
    .o_is_status (w_is_status),
    .o_is_data   (w_is_data),
    .o_type      (w_type),
    .o_chan      (w_chan),
    .o_skip_len  (w_skip_len)
  );

  // Channel is compared at the moment the status byte is accepted
  assign w_match = (OMNI != 0) || (w_chan == i_channel);
  assign w_data  = i_byte_in[6:0];

  // Message FSM, data-byte capture and registered pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_type     <= 4'h0;
      r_d1       <= 7'd0;
      r_skip_len <= 2'd0;
      r_skip_cnt <= 2'd0;
      r_note_on  <= 1'b0;
      r_note_off <= 1'b0;
      r_all_off  <= 1'b0;
      r_note     <= 7'd0;
      r_velocity <= 7'd0;
    end else begin
      r_note_on  <= 1'b0;
      r_note_off <= 1'b0;
      r_all_off  <= 1'b0;
      if (i_byte_valid) begin
        if (w_is_rt) begin
          // Realtime bytes are transparent: nothing changes
          r_state <= r_state;
        end else if (w_is_sys) begin
          r_state <= S_IDLE;
        end else if (w_is_status) begin
          r_type     <= w_type;
          r_skip_len <= w_skip_len;
          r_skip_cnt <= 2'd0;
          r_state    <= (w_match && is_supported(w_type)) ? S_WAIT_D1 : S_SKIP;
        end else if (w_is_data) begin
          case (r_state)
            S_WAIT_D1: begin
              r_d1    <= w_data;
              r_state <= S_WAIT_D2;
            end
            S_WAIT_D2: begin
              r_state <= S_WAIT_D1;
              if (r_type == ST_NOTE_ON) begin
                r_note     <= r_d1;
                r_velocity <= w_data;
                if (w_data != 7'd0) r_note_on <= 1'b1;
                else                r_note_off <= 1'b1;
              end else if (r_type == ST_NOTE_OFF) begin
                r_note     <= r_d1;
                r_velocity <= w_data;
                r_note_off <= 1'b1;
              end else if (r_type == ST_CC) begin
                if ((r_d1 == CC_ALL_SOUND_OFF) || (r_d1 == CC_ALL_NOTES_OFF))
                  r_all_off <= 1'b1;
              end
            end
            S_SKIP: begin
              // Walk through the data of an ignored message, then re-arm
              if ((r_skip_cnt + 2'd1) >= r_skip_len) r_skip_cnt <= 2'd0;
              else                                  r_skip_cnt <= r_skip_cnt + 2'd1;
            end
            default: r_state <= r_state;
          endcase
        end
      end
    end
  end

  assign o_note_on  = r_note_on;
  assign o_note_off = r_note_off;
  assign o_all_off  = r_all_off;
  assign o_note     = r_note;
  assign o_velocity = r_velocity;
  assign o_state    = r_state;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Bench for midi_note_decoder: OMNI=0 and OMNI=1 instances share one byte stream.
module tb_midi_note_decoder;

  localparam int W = 48;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  kind;   // 1 note_on, 2 note_off, 3 all_off
    logic [6:0]  note;
    logic [6:0]  vel;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_byte_valid = 1'b0;
  logic [7:0] i_byte_in = 8'h00;
  logic [3:0] i_channel = 4'h0;

  logic       on0, off0, all0, on1, off1, all1;
  logic [6:0] note0, vel0, note1, vel1;
  logic [1:0] st0, st1;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  midi_note_decoder #(.OMNI(0)) dut0 (
    .clk(clk), .rst(rst), .i_byte_valid(i_byte_valid), .i_byte_in(i_byte_in),
    .i_channel(i_channel), .o_note_on(on0), .o_note_off(off0), .o_note(note0),
    .o_velocity(vel0), .o_all_off(all0), .o_state(st0));

  midi_note_decoder #(.OMNI(1)) dut1 (
    .clk(clk), .rst(rst), .i_byte_valid(i_byte_valid), .i_byte_in(i_byte_in),
    .i_channel(i_channel), .o_note_on(on1), .o_note_off(off1), .o_note(note1),
    .o_velocity(vel1), .o_all_off(all1), .o_state(st1));

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic q_push(input int idx, input exp_t e);
    if (idx == 0) exp_q0.push_back(e);
    else          exp_q1.push_back(e);
  endtask

  function automatic int q_size(input int idx);
    return (idx == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic exp_t q_front(input int idx);
    return (idx == 0) ? exp_t'(exp_q0[0]) : exp_t'(exp_q1[0]);
  endfunction

  task automatic q_pop(input int idx);
    if (idx == 0) void'(exp_q0.pop_front());
    else          void'(exp_q1.pop_front());
  endtask

  // ---------------- reference model ----------------
  // Message-level view: what kind of message is currently "running", and
  // which data bytes of it have been collected so far.
  int m_kind[2];      // 0 nothing running, 1 decoded message, 2 ignored message
  int m_type[2];
  int m_data[2][$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_kind[i] = 0;
      m_type[i] = 0;
      m_data[i].delete();
    end
  endtask

  task automatic model_byte(input int b);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (b >= 'hF8) begin
        // realtime: invisible
      end else if (b >= 'hF0) begin
        m_kind[i] = 0;
        m_data[i].delete();
      end else if (b >= 'h80) begin
        int t, ch;
        bit listen;
        t = b / 16;
        ch = b % 16;
        listen = (i == 1) || (ch == int'(i_channel));
        m_type[i] = t;
        m_kind[i] = (listen && (t == 8 || t == 9 || t == 11)) ? 1 : 2;
        m_data[i].delete();
      end else if (m_kind[i] == 1) begin
        m_data[i].push_back(b);
        if (m_data[i].size() == 2) begin
          int key, val;
          key = m_data[i][0];
          val = m_data[i][1];
          m_data[i].delete();
          e.cyc  = cyc + 1;
          e.note = 7'(key);
          e.vel  = 7'(val);
          e.kind = 2'd0;
          if (m_type[i] == 9)      e.kind = (val != 0) ? 2'd1 : 2'd2;
          else if (m_type[i] == 8) e.kind = 2'd2;
          else if (key == 120 || key == 123) e.kind = 2'd3;
          if (e.kind != 2'd0) q_push(i, e);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int b);
    i_byte_valid = 1'b1;
    i_byte_in    = 8'(b);
    model_byte(b);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_seq(input int len, input int b0, input int b1, input int b2,
                          input int b3, input int b4, input int b5);
    int s[6];
    s = '{b0, b1, b2, b3, b4, b5};
    for (int k = 0; k < len; k++) send(s[k]);
    idle(3);
  endtask

  task automatic do_reset();
    idle(1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  logic [6:0] last_note[2];
  logic [6:0] last_vel[2];

  task automatic mon(input int idx, input logic on, input logic off, input logic all,
                     input logic [6:0] n, input logic [6:0] v);
    int npulse;
    int kind;
    exp_t e;
    npulse = int'(on) + int'(off) + int'(all);
    if (npulse > 1) chk("pulse_exclusive", npulse, 1);
    if (npulse == 0) begin
      if (q_size(idx) > 0) begin
        e = q_front(idx);
        if (e.cyc < cyc) begin
          chk("missing_pulse_kind", 0, int'(e.kind));
          q_pop(idx);
        end
      end
      chk("held_note", int'(n), int'(last_note[idx]));
      chk("held_velocity", int'(v), int'(last_vel[idx]));
    end else begin
      kind = on ? 1 : (off ? 2 : 3);
      if (q_size(idx) == 0) begin
        chk("unexpected_pulse_kind", kind, 0);
      end else begin
        e = q_front(idx);
        q_pop(idx);
        chk("pulse_cycle", int'(cyc), int'(e.cyc));
        chk("pulse_kind", kind, int'(e.kind));
        if (e.kind != 2'd3) begin
          chk("note", int'(n), int'(e.note));
          chk("velocity", int'(v), int'(e.vel));
          last_note[idx] = e.note;
          last_vel[idx]  = e.vel;
        end else begin
          chk("note_hold_on_all_off", int'(n), int'(last_note[idx]));
          chk("vel_hold_on_all_off", int'(v), int'(last_vel[idx]));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        last_note[i] = 7'd0;
        last_vel[i]  = 7'd0;
      end
    end else begin
      mon(0, on0, off0, all0, note0, vel0);
      mon(1, on1, off1, all1, note1, vel1);
    end
  end

  // ---------------- random byte generator ----------------
  function automatic int rand_byte();
    int c;
    int sel;
    c = $urandom_range(0, 99);
    if (c < 55) begin
      if ($urandom_range(0, 4) == 0) begin
        sel = $urandom_range(0, 2);
        return (sel == 0) ? 120 : ((sel == 1) ? 123 : 0);
      end
      return $urandom_range(0, 127);
    end else if (c < 80) begin
      sel = $urandom_range(0, 2);
      return ((sel == 0) ? 'h80 : ((sel == 1) ? 'h90 : 'hB0)) +
             (($urandom_range(0, 1) == 0) ? int'(i_channel) : $urandom_range(0, 15));
    end else if (c < 88) begin
      sel = $urandom_range(0, 3);
      return ((sel == 0) ? 'hA0 : ((sel == 1) ? 'hC0 : ((sel == 2) ? 'hD0 : 'hE0))) +
             $urandom_range(0, 15);
    end else if (c < 92) begin
      return $urandom_range('hF0, 'hF7);
    end
    return $urandom_range('hF8, 'hFF);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // reset state of both instances
    chk("reset_note_on", int'(on0) + int'(on1), 0);
    chk("reset_note_off", int'(off0) + int'(off1), 0);
    chk("reset_all_off", int'(all0) + int'(all1), 0);
    chk("reset_note", int'(note0) + int'(note1), 0);
    chk("reset_velocity", int'(vel0) + int'(vel1), 0);
    chk("reset_state0", int'(st0), 0);
    chk("reset_state1", int'(st1), 0);

    // data at power-up is never a note
    send_seq(2, 'h3C, 'h64, 0, 0, 0, 0);
    // basic note on
    send_seq(3, 'h90, 'h3C, 'h64, 0, 0, 0);
    // running status with velocity-0 note off
    send_seq(5, 'h90, 'h3C, 'h64, 'h40, 'h00, 0);
    // realtime interleaved
    send_seq(5, 'h90, 'hF8, 'h3C, 'hFE, 'h64, 0);
    // other channel: only the OMNI instance reacts
    send_seq(3, 'h91, 'h3C, 'h64, 0, 0, 0);
    // explicit note off keeps its velocity
    send_seq(3, 'h80, 'h45, 'h22, 0, 0, 0);
    // skipped program change
    send_seq(3, 'hC0, 'h05, 'h3C, 0, 0, 0);
    // sysex clears running status
    send_seq(6, 'hF0, 'h3C, 'h64, 'hF7, 'h3C, 'h64);
    // all notes off, all sound off, ordinary CC
    send_seq(3, 'hB0, 'h7B, 'h00, 0, 0, 0);
    send_seq(5, 'hB0, 'h78, 'h00, 'h07, 'h50, 0);
    // status aborts a partial message
    send_seq(4, 'h90, 'h3C, 'h90, 'h41, 0, 0);
    send(int'('h22));
    idle(3);
    // reset mid-message: nothing decoded afterwards
    send(int'('h90));
    send(int'('h3C));
    do_reset();
    chk("midreset_state0", int'(st0), 0);
    send_seq(2, 'h64, 'h00, 0, 0, 0, 0);

    // randomized stream
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else if ($urandom_range(0, 99) < 4) idle($urandom_range(1, 2));
      else begin
        if ($urandom_range(0, 99) < 3) i_channel = 4'($urandom_range(0, 15));
        send(rand_byte());
      end
    end
    idle(5);
    chk("leftover_expected0", exp_q0.size(), 0);
    chk("leftover_expected1", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
